// File: rtl/pong_pkg.sv
// Shared geometry, derived limits, enums and small helpers for the pong game-logic stage.
// The renderer imports the same constants so both sides agree on object sizes.
package pong_pkg;

    localparam int unsigned SCR_W     = 640;
    localparam int unsigned SCR_H     = 480;
    localparam int unsigned PAD_W     = 8;
    localparam int unsigned PAD_H     = 64;
    localparam int unsigned PAD_XL    = 16;
    localparam int unsigned PAD_XR    = 616;
    localparam int unsigned BALL_S    = 8;
    localparam int unsigned PAD_SPD   = 4;
    localparam int unsigned BALL_SPD  = 2;
    localparam int unsigned WIN_SCORE = 9;
    localparam int unsigned PAUSE_FR  = 60;

    // Derived limits: 416, 472, 632, 24, 608, 316, 236, 208
    localparam int unsigned PAD_Y_MAX  = SCR_H - PAD_H;
    localparam int unsigned BALL_Y_MAX = SCR_H - BALL_S;
    localparam int unsigned BALL_X_MAX = SCR_W - BALL_S;
    localparam int unsigned HIT_XL     = PAD_XL + PAD_W;
    localparam int unsigned HIT_XR     = PAD_XR - BALL_S;
    localparam int unsigned BALL_X0    = (SCR_W - BALL_S) / 2;
    localparam int unsigned BALL_Y0    = (SCR_H - BALL_S) / 2;
    localparam int unsigned PAD_Y0     = (SCR_H - PAD_H) / 2;

    localparam int unsigned POS_W   = 10;
    localparam int unsigned CALC_W  = 11;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned KEY_W   = 4;

    typedef enum logic [1:0] {
        GS_SERVE = 2'd0,
        GS_PLAY  = 2'd1,
        GS_POINT = 2'd2,
        GS_OVER  = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_PAD  = 2'd1,
        SEQ_BALL = 2'd2,
        SEQ_COLL = 2'd3
    } seq_step_t;

    // Score increment that sticks at the winning score.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        if (s >= SCORE_W'(WIN_SCORE)) begin
            return SCORE_W'(WIN_SCORE);
        end
        return s + SCORE_W'(1);
    endfunction

    // Widen an unsigned screen coordinate into the signed working width.
    function automatic logic signed [CALC_W-1:0] to_calc(input logic [POS_W-1:0] v);
        return $signed(CALC_W'(v));
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: moves by PAD_SPD on an enable strobe from its up/down key pair,
// clamped to the playfield; both or neither key held leaves it in place.
module pong_paddle
    import pong_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_dn,
    output logic [POS_W-1:0] o_y
);

    localparam logic signed [CALC_W-1:0] C_SPD   = CALC_W'(PAD_SPD);
    localparam logic signed [CALC_W-1:0] C_Y_MAX = CALC_W'(PAD_Y_MAX);

    logic [POS_W-1:0]         r_y;
    logic signed [CALC_W-1:0] w_y;
    logic signed [CALC_W-1:0] w_up;
    logic signed [CALC_W-1:0] w_dn;

    assign w_y  = to_calc(r_y);
    assign w_up = w_y - C_SPD;
    assign w_dn = w_y + C_SPD;

    // Signed working width lets the top clamp test the sign bit instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_y <= POS_W'(PAD_Y0);
        end else if (i_en) begin
            if (i_up && !i_dn) begin
                r_y <= w_up[CALC_W-1] ? '0 : w_up[POS_W-1:0];
            end else if (i_dn && !i_up) begin
                r_y <= (w_dn > C_Y_MAX) ? POS_W'(PAD_Y_MAX) : w_dn[POS_W-1:0];
            end
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/pong_engine.sv
// Pong game logic: on each accepted frame tick runs PAD -> BALL -> COLL and commits
// paddles, ball, scores and game state; outputs hold steady between updates.
module pong_engine
    import pong_pkg::*;
(
    input  logic                clock_25,
    input  logic                reset_n,
    input  logic                frame_tick,
    input  logic [KEY_W-1:0]    key,
    output logic [POS_W-1:0]    ball_x,
    output logic [POS_W-1:0]    ball_y,
    output logic [POS_W-1:0]    pad_l_y,
    output logic [POS_W-1:0]    pad_r_y,
    output logic [SCORE_W-1:0]  score_l,
    output logic [SCORE_W-1:0]  score_r,
    output logic [1:0]          game_state,
    output logic                upd_done
);

    localparam logic signed [CALC_W-1:0] C_ZERO      = '0;
    localparam logic signed [CALC_W-1:0] C_BSPD      = CALC_W'(BALL_SPD);
    localparam logic signed [CALC_W-1:0] C_BSIZE     = CALC_W'(BALL_S);
    localparam logic signed [CALC_W-1:0] C_PAD_H     = CALC_W'(PAD_H);
    localparam logic signed [CALC_W-1:0] C_PAD_XL    = CALC_W'(PAD_XL);
    localparam logic signed [CALC_W-1:0] C_PAD_XR    = CALC_W'(PAD_XR);
    localparam logic signed [CALC_W-1:0] C_PAD_XR_E  = CALC_W'(PAD_XR + PAD_W);
    localparam logic signed [CALC_W-1:0] C_HIT_XL    = CALC_W'(HIT_XL);
    localparam logic signed [CALC_W-1:0] C_HIT_XR    = CALC_W'(HIT_XR);
    localparam logic signed [CALC_W-1:0] C_BX_MAX    = CALC_W'(BALL_X_MAX);
    localparam logic signed [CALC_W-1:0] C_BY_MAX    = CALC_W'(BALL_Y_MAX);
    localparam logic signed [CALC_W-1:0] C_BX0       = CALC_W'(BALL_X0);
    localparam logic signed [CALC_W-1:0] C_BY0       = CALC_W'(BALL_Y0);

    seq_step_t                r_step;
    game_state_t              r_state;
    logic signed [CALC_W-1:0] r_ball_x;
    logic signed [CALC_W-1:0] r_ball_y;
    logic                     r_dx;
    logic                     r_dy;
    logic [SCORE_W-1:0]       r_score_l;
    logic [SCORE_W-1:0]       r_score_r;
    logic [CNT_W-1:0]         r_pause;
    logic [KEY_W-1:0]         r_key;
    logic [KEY_W-1:0]         r_key_prev;
    logic                     r_upd_done;

    logic [POS_W-1:0]         w_pad_l_y;
    logic [POS_W-1:0]         w_pad_r_y;
    logic                     w_pad_en;
    logic signed [CALC_W-1:0] w_pl;
    logic signed [CALC_W-1:0] w_pr;
    logic signed [CALC_W-1:0] w_ball_r;
    logic signed [CALC_W-1:0] w_ball_b;
    logic signed [CALC_W-1:0] w_bx_mv;
    logic signed [CALC_W-1:0] w_by_mv;
    logic                     w_ov_l;
    logic                     w_ov_r;
    logic                     w_hit_l;
    logic                     w_hit_r;
    logic                     w_miss_l;
    logic                     w_miss_r;
    logic                     w_key_any;
    logic                     w_key_rise;
    logic [SCORE_W-1:0]       w_score_l_inc;
    logic [SCORE_W-1:0]       w_score_r_inc;

    // Paddles move during the PAD step in every state except OVER.
    assign w_pad_en = (r_step == SEQ_PAD) && (r_state != GS_OVER);

    pong_paddle u_pad_l (
        .i_clk   (clock_25),
        .i_rst_n (reset_n),
        .i_en    (w_pad_en),
        .i_up    (r_key[0]),
        .i_dn    (r_key[1]),
        .o_y     (w_pad_l_y)
    );

    pong_paddle u_pad_r (
        .i_clk   (clock_25),
        .i_rst_n (reset_n),
        .i_en    (w_pad_en),
        .i_up    (r_key[2]),
        .i_dn    (r_key[3]),
        .o_y     (w_pad_r_y)
    );

    assign w_pl     = to_calc(w_pad_l_y);
    assign w_pr     = to_calc(w_pad_r_y);
    assign w_ball_r = r_ball_x + C_BSIZE;
    assign w_ball_b = r_ball_y + C_BSIZE;
    assign w_bx_mv  = r_dx ? (r_ball_x + C_BSPD) : (r_ball_x - C_BSPD);
    assign w_by_mv  = r_dy ? (r_ball_y + C_BSPD) : (r_ball_y - C_BSPD);

    assign w_ov_l   = (w_ball_b > w_pl) && (r_ball_y < (w_pl + C_PAD_H));
    assign w_ov_r   = (w_ball_b > w_pr) && (r_ball_y < (w_pr + C_PAD_H));
    assign w_hit_l  = !r_dx && (r_ball_x <= C_HIT_XL) && (w_ball_r > C_PAD_XL) && w_ov_l;
    assign w_hit_r  = r_dx && (w_ball_r >= C_PAD_XR) && (r_ball_x < C_PAD_XR_E) && w_ov_r;
    assign w_miss_l = (r_ball_x <= C_ZERO);
    assign w_miss_r = (r_ball_x >= C_BX_MAX);

    assign w_key_any     = |r_key;
    assign w_key_rise    = |(r_key & ~r_key_prev);
    assign w_score_l_inc = score_inc(r_score_l);
    assign w_score_r_inc = score_inc(r_score_r);

    // Update sequencer and game state; frame ticks outside IDLE are dropped.
    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            r_step     <= SEQ_IDLE;
            r_state    <= GS_SERVE;
            r_ball_x   <= C_BX0;
            r_ball_y   <= C_BY0;
            r_dx       <= 1'b1;
            r_dy       <= 1'b1;
            r_score_l  <= '0;
            r_score_r  <= '0;
            r_pause    <= '0;
            r_key      <= '0;
            r_key_prev <= '0;
            r_upd_done <= 1'b0;
        end else begin
            r_upd_done <= 1'b0;
            case (r_step)
                SEQ_IDLE: begin
                    if (frame_tick) begin
                        r_step     <= SEQ_PAD;
                        r_key      <= key;
                        r_key_prev <= r_key;
                    end
                end
                SEQ_PAD: begin
                    r_step <= SEQ_BALL;
                end
                SEQ_BALL: begin
                    r_step <= SEQ_COLL;
                    if (r_state == GS_PLAY) begin
                        r_ball_x <= w_bx_mv;
                        if (w_by_mv <= C_ZERO) begin
                            r_ball_y <= C_ZERO;
                            r_dy     <= 1'b1;
                        end else if (w_by_mv >= C_BY_MAX) begin
                            r_ball_y <= C_BY_MAX;
                            r_dy     <= 1'b0;
                        end else begin
                            r_ball_y <= w_by_mv;
                        end
                    end
                end
                SEQ_COLL: begin
                    r_step     <= SEQ_IDLE;
                    r_upd_done <= 1'b1;
                    case (r_state)
                        GS_SERVE: begin
                            if (w_key_any) begin
                                r_state <= GS_PLAY;
                            end
                        end
                        GS_PLAY: begin
                            if (w_hit_l) begin
                                r_ball_x <= C_HIT_XL;
                                r_dx     <= 1'b1;
                            end else if (w_hit_r) begin
                                r_ball_x <= C_HIT_XR;
                                r_dx     <= 1'b0;
                            end else if (w_miss_l) begin
                                r_score_r <= w_score_r_inc;
                                r_dx      <= 1'b0;
                                r_ball_x  <= C_BX0;
                                r_ball_y  <= C_BY0;
                                r_pause   <= CNT_W'(PAUSE_FR);
                                r_state   <= (w_score_r_inc == SCORE_W'(WIN_SCORE)) ? GS_OVER : GS_POINT;
                            end else if (w_miss_r) begin
                                r_score_l <= w_score_l_inc;
                                r_dx      <= 1'b1;
                                r_ball_x  <= C_BX0;
                                r_ball_y  <= C_BY0;
                                r_pause   <= CNT_W'(PAUSE_FR);
                                r_state   <= (w_score_l_inc == SCORE_W'(WIN_SCORE)) ? GS_OVER : GS_POINT;
                            end
                        end
                        GS_POINT: begin
                            if (r_pause <= CNT_W'(1)) begin
                                r_pause <= '0;
                                r_state <= GS_PLAY;
                            end else begin
                                r_pause <= r_pause - CNT_W'(1);
                            end
                        end
                        GS_OVER: begin
                            if (w_key_rise) begin
                                r_state   <= GS_SERVE;
                                r_score_l <= '0;
                                r_score_r <= '0;
                                r_ball_x  <= C_BX0;
                                r_ball_y  <= C_BY0;
                                r_dx      <= 1'b1;
                                r_dy      <= 1'b1;
                            end
                        end
                        default: r_state <= GS_SERVE;
                    endcase
                end
                default: r_step <= SEQ_IDLE;
            endcase
        end
    end

    assign ball_x     = r_ball_x[POS_W-1:0];
    assign ball_y     = r_ball_y[POS_W-1:0];
    assign pad_l_y    = w_pad_l_y;
    assign pad_r_y    = w_pad_r_y;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign game_state = r_state;
    assign upd_done   = r_upd_done;

endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: directed frames plus long randomized key play, each frame
// checked against an integer game model that applies one whole frame at a time.
module tb_pong_engine;

    localparam int ST_SERVE = 0;
    localparam int ST_PLAY  = 1;
    localparam int ST_POINT = 2;
    localparam int ST_OVER  = 3;

    logic       clock_25   = 1'b0;
    logic       reset_n    = 1'b0;
    logic       frame_tick = 1'b0;
    logic [3:0] key        = 4'd0;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] pad_l_y;
    logic [9:0] pad_r_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] game_state;
    logic       upd_done;

    pong_engine dut (
        .clock_25   (clock_25),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .key        (key),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .pad_l_y    (pad_l_y),
        .pad_r_y    (pad_r_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_state (game_state),
        .upd_done   (upd_done)
    );

    always #5 clock_25 = ~clock_25;

    int n_checks = 0;
    int n_errors = 0;

    // Game model: whole-frame integer update.
    int         m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_st, m_cnt;
    logic [3:0] m_prev;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pad_move(input int y, input bit up, input bit dn);
        if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
        return y;
    endfunction

    task automatic model_reset();
        m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
        m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0;
        m_st = ST_SERVE; m_cnt = 0; m_prev = 4'd0;
    endtask

    task automatic model_point(input int new_score);
        m_bx  = 316;
        m_by  = 236;
        m_cnt = 60;
        m_st  = (new_score == 9) ? ST_OVER : ST_POINT;
    endtask

    task automatic model_frame(input logic [3:0] k);
        bit ovl, ovr;
        if (m_st != ST_OVER) begin
            m_pl = pad_move(m_pl, k[0], k[1]);
            m_pr = pad_move(m_pr, k[2], k[3]);
        end
        if (m_st == ST_PLAY) begin
            m_bx += 2 * m_dx;
            m_by += 2 * m_dy;
            if (m_by <= 0) begin
                m_by = 0; m_dy = 1;
            end else if (m_by >= 472) begin
                m_by = 472; m_dy = -1;
            end
        end
        case (m_st)
            ST_SERVE: if (k != 4'd0) m_st = ST_PLAY;
            ST_PLAY: begin
                ovl = (m_by + 8 > m_pl) && (m_by < m_pl + 64);
                ovr = (m_by + 8 > m_pr) && (m_by < m_pr + 64);
                if (m_dx < 0 && m_bx <= 24 && m_bx + 8 > 16 && ovl) begin
                    m_bx = 24; m_dx = 1;
                end else if (m_dx > 0 && m_bx + 8 >= 616 && m_bx < 624 && ovr) begin
                    m_bx = 608; m_dx = -1;
                end else if (m_bx <= 0) begin
                    m_sr = (m_sr >= 9) ? 9 : m_sr + 1;
                    m_dx = -1;
                    model_point(m_sr);
                end else if (m_bx >= 632) begin
                    m_sl = (m_sl >= 9) ? 9 : m_sl + 1;
                    m_dx = 1;
                    model_point(m_sl);
                end
            end
            ST_POINT: begin
                if (m_cnt <= 1) begin
                    m_cnt = 0; m_st = ST_PLAY;
                end else begin
                    m_cnt--;
                end
            end
            default: begin
                if ((k & ~m_prev) != 4'd0) begin
                    m_st = ST_SERVE; m_sl = 0; m_sr = 0;
                    m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
                end
            end
        endcase
        m_prev = k;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".ball_x"},  32'(ball_x),     32'(m_bx));
        check_eq({tag, ".ball_y"},  32'(ball_y),     32'(m_by));
        check_eq({tag, ".pad_l_y"}, 32'(pad_l_y),    32'(m_pl));
        check_eq({tag, ".pad_r_y"}, 32'(pad_r_y),    32'(m_pr));
        check_eq({tag, ".score_l"}, 32'(score_l),    32'(m_sl));
        check_eq({tag, ".score_r"}, 32'(score_r),    32'(m_sr));
        check_eq({tag, ".state"},   32'(game_state), 32'(m_st));
    endtask

    // One frame; keys are scrambled after the tick so only the sampled value may count.
    task automatic run_frame(input logic [3:0] k, input bit dbl_tick);
        @(negedge clock_25);
        key        = k;
        frame_tick = 1'b1;
        @(negedge clock_25);
        key        = 4'($urandom);
        frame_tick = dbl_tick;
        check_eq("upd_c1", 32'(upd_done), 32'd0);
        @(negedge clock_25);
        frame_tick = 1'b0;
        check_eq("upd_c2", 32'(upd_done), 32'd0);
        @(negedge clock_25);
        check_eq("upd_c3", 32'(upd_done), 32'd0);
        @(negedge clock_25);
        check_eq("upd_pulse", 32'(upd_done), 32'd1);
        model_frame(k);
        check_outputs("frame");
        @(negedge clock_25);
        check_eq("upd_clear", 32'(upd_done), 32'd0);
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        key        = 4'd0;
        repeat (3) @(negedge clock_25);
        model_reset();
        check_outputs("reset");
        check_eq("reset.upd", 32'(upd_done), 32'd0);
        reset_n = 1'b1;
    endtask

    // Reset asserted while the sequencer sits in the BALL step.
    task automatic reset_in_ball(input logic [3:0] k);
        @(negedge clock_25);
        key        = k;
        frame_tick = 1'b1;
        @(negedge clock_25);
        frame_tick = 1'b0;
        @(negedge clock_25);
        reset_n = 1'b0;
        @(negedge clock_25);
        model_reset();
        check_outputs("midrst");
        check_eq("midrst.upd", 32'(upd_done), 32'd0);
        reset_n = 1'b1;
        key     = 4'd0;
        @(negedge clock_25);
        check_eq("midrst.idle", 32'(upd_done), 32'd0);
    endtask

    initial begin
        apply_reset();

        for (int i = 0; i < 3; i++) run_frame(4'b0000, 1'b0);

        for (int i = 1; i <= 60; i++) begin
            run_frame(4'b0001, 1'b0);
            if (i == 51) check_eq("pad_l_near_floor", 32'(pad_l_y), 32'd4);
            if (i == 52) check_eq("pad_l_floor", 32'(pad_l_y), 32'd0);
        end
        check_eq("pad_l_clamped", 32'(pad_l_y), 32'd0);

        for (int i = 0; i < 20; i++) run_frame(4'b0011, 1'b0);

        run_frame(4'b0011, 1'b1);
        reset_in_ball(4'b0011);
        run_frame(4'b0000, 1'b0);

        // Left paddle pinned at the top so the right player piles up points.
        for (int i = 0; i < 2500; i++) begin
            run_frame({2'($urandom_range(0, 3)), 2'b01}, 1'b0);
        end

        for (int i = 0; i < 1000; i++) begin
            run_frame(4'($urandom_range(0, 15)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
